// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding,
//   the maximum supported operand width, and the state decode helper that
//   folds the unused encoding back onto IDLE.
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int WIDTH_MAX = 32;

  // 2'd3 is never entered by the FSM; should it ever appear it behaves as
  // IDLE so the block recovers on the next start without needing a reset.
  function automatic logic [1:0] state_decode(input logic [1:0] s);
    logic [1:0] r;
    r = ST_IDLE;
    case (s)
      ST_SHIFT: r = ST_SHIFT;
      ST_DONE:  r = ST_DONE;
      default:  r = ST_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// ---------------------------------------------------------------------------
// fs_cell
//   Purely combinational one-bit full subtractor: x - y - bi.
//   Ports:
//     x   in  minuend bit
//     y   in  subtrahend bit
//     bi  in  borrow in
//     dif out difference bit
//     bo  out borrow out
// ---------------------------------------------------------------------------
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic dif,
  output logic bo
);

  logic xy_diff;

  assign xy_diff = x ^ y;
  assign dif     = xy_diff ^ bi;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bo      = (~x & y) | (~xy_diff & bi);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing d = a - b - bin, LSB first,
//   one bit per clock through a single fs_cell and a borrow flip-flop.
//   Handshake: start is sampled in IDLE only; busy is high for the WIDTH
//   shift cycles; done pulses for one cycle when d/bout are updated.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  synchronous active-high reset
//     start in  request, sampled only in IDLE
//     a     in  minuend, captured on accepted start
//     b     in  subtrahend, captured on accepted start
//     bin   in  initial borrow, captured on accepted start
//     busy  out high during SHIFT
//     done  out one-cycle pulse, d/bout valid
//     d     out difference, held until the next result
//     bout  out final borrow-out (1 iff a < b + bin, unsigned)
//   WIDTH must lie in 1..WIDTH_MAX.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_cur;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_shift;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             dif;
  logic             bo;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             unused_lsb;

  fs_cell u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bi  (br),
    .dif (dif),
    .bo  (bo)
  );

  assign state_cur = state_decode(state);
  assign accept    = (state_cur == ST_IDLE) && start;
  assign shifting  = (state_cur == ST_SHIFT);
  assign last_bit  = (cnt == CNT_LAST);

  // The new difference bit enters at the top; after WIDTH shifts bit 0 of
  // the result has walked down to position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign d_shift = dif;
    end else begin : g_wn
      assign d_shift = {dif, d_sr[WIDTH-1:1]};
    end
  endgenerate

  // The bit shifted out of d_sr is discarded by construction.
  assign unused_lsb = d_sr[0];

  always_comb begin
    state_nxt = ST_IDLE;
    case (state_cur)
      ST_SHIFT: state_nxt = last_bit ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = start ? ST_SHIFT : ST_IDLE;
    endcase
  end

  // ---- control: FSM, registered flags, counter, borrow, result ----------
  // busy/done are registered from the next state so they are glitch-free
  // and line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      br    <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_SHIFT);
      done  <= (state_nxt == ST_DONE);
      if (accept) begin
        cnt <= '0;
        br  <= bin;
      end else if (shifting) begin
        cnt <= cnt + 1'b1;
        br  <= bo;
      end
      // Result registers only move on the edge that completes the last bit,
      // so the previous result stays visible throughout the next operation.
      if (shifting && last_bit) begin
        d    <= d_shift;
        bout <= bo;
      end
    end
  end

  // ---- datapath: operand and difference shift registers -----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b;
      d_sr <= '0;
    end else if (shifting) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_shift;
    end
  end

endmodule
